// File: rtl/dtree_feeder.sv
// dtree_feeder: holds one feature vector, streams it into the decision tree
// one feature per cycle, and returns the tree's tagged result downstream.
module dtree_feeder #(
  parameter int FEATURES  = 3,
  parameter int IN_WIDTH  = 10,
  parameter int TAG_WIDTH = 4,
  parameter int TIMEOUT   = 64,
  localparam int LW = (FEATURES > 1) ? $clog2(FEATURES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FEATURES*IN_WIDTH-1:0] in_features,
  input  logic                         tree_ready,
  output logic [IN_WIDTH-1:0]          sample,
  input  logic [LW-1:0]                tree_level,
  input  logic [LW-1:0]                tree_path,
  input  logic                         tree_out_valid,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [LW-1:0]                res_level,
  output logic [LW-1:0]                res_path,
  output logic [TAG_WIDTH-1:0]         res_tag,
  output logic                         timeout_err,
  output logic                         spurious_err
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [LW-1:0] LAST_IDX = LW'(FEATURES - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOADED, S_SEND, S_WAIT} state_t;

  state_t                        state_q, state_d;
  logic [LW-1:0]                 idx_q, idx_d;
  logic [TAG_WIDTH-1:0]          tag_q, tag_d;
  logic [FEATURES*IN_WIDTH-1:0]  vec_q, vec_d;
  logic                          res_valid_q, res_valid_d;
  logic [LW-1:0]                 res_level_q, res_level_d;
  logic [LW-1:0]                 res_path_q, res_path_d;
  logic [TAG_WIDTH-1:0]          res_tag_q, res_tag_d;
  logic [WW-1:0]                 wd_q, wd_d;
  logic                          timeout_err_q, timeout_err_d;
  logic                          spurious_err_q, spurious_err_d;

  // Feature mux: sample always shows the held feature selected by idx.
  always_comb begin
    sample = '0;
    for (int k = 0; k < FEATURES; k++)
      if (idx_q == LW'(k)) sample = vec_q[k*IN_WIDTH +: IN_WIDTH];
  end

  assign in_ready     = (state_q == S_IDLE);
  assign res_valid    = res_valid_q;
  assign res_level    = res_level_q;
  assign res_path     = res_path_q;
  assign res_tag      = res_tag_q;
  assign timeout_err  = timeout_err_q;
  assign spurious_err = spurious_err_q;

  // Next-state: sequencing FSM, watchdog, result slot and sticky errors.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    tag_d          = tag_q;
    vec_d          = vec_q;
    res_valid_d    = res_valid_q;
    res_level_d    = res_level_q;
    res_path_d     = res_path_q;
    res_tag_d      = res_tag_q;
    wd_d           = wd_q;
    timeout_err_d  = timeout_err_q;
    spurious_err_d = spurious_err_q;

    // Drain first; a capture below can only happen when the slot is empty.
    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    if (tree_out_valid && state_q != S_WAIT) spurious_err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          vec_d   = in_features;
          tag_d   = tag_q + TAG_WIDTH'(1);
          idx_d   = '0;
          state_d = S_LOADED;
        end
      end
      S_LOADED: begin
        // Start is gated by the result slot so an unread result is never overwritten.
        if (tree_ready && !res_valid_q) begin
          if (FEATURES == 1) begin
            wd_d    = '0;
            state_d = S_WAIT;
          end else begin
            idx_d   = LW'(1);
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          wd_d    = '0;
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      S_WAIT: begin
        // An answer on the final watchdog cycle wins over the timeout.
        if (tree_out_valid) begin
          res_level_d = tree_level;
          res_path_d  = tree_path;
          res_tag_d   = tag_q;
          res_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      tag_q          <= '0;
      vec_q          <= '0;
      res_valid_q    <= 1'b0;
      res_level_q    <= '0;
      res_path_q     <= '0;
      res_tag_q      <= '0;
      wd_q           <= '0;
      timeout_err_q  <= 1'b0;
      spurious_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      tag_q          <= tag_d;
      vec_q          <= vec_d;
      res_valid_q    <= res_valid_d;
      res_level_q    <= res_level_d;
      res_path_q     <= res_path_d;
      res_tag_q      <= res_tag_d;
      wd_q           <= wd_d;
      timeout_err_q  <= timeout_err_d;
      spurious_err_q <= spurious_err_d;
    end
  end

endmodule

// File: tb/tb_dtree_feeder.sv
// tb_dtree_feeder: directed sequence with a result scoreboard for dtree_feeder.
module tb_dtree_feeder;

  localparam int F = 3, W = 10, T = 4, TO = 8, LW = 2;

  logic           clk = 1'b0;
  logic           reset, in_valid, in_ready, tree_ready, tree_out_valid;
  logic [F*W-1:0] in_features;
  logic [W-1:0]   sample;
  logic [LW-1:0]  tree_level, tree_path, res_level, res_path;
  logic           res_valid, res_ready, timeout_err, spurious_err;
  logic [T-1:0]   res_tag;

  typedef struct packed {
    logic [LW-1:0] lvl;
    logic [LW-1:0] pth;
    logic [T-1:0]  tag;
  } res_t;

  res_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  dtree_feeder #(.FEATURES(F), .IN_WIDTH(W), .TAG_WIDTH(T), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_features(in_features), .tree_ready(tree_ready), .sample(sample),
    .tree_level(tree_level), .tree_path(tree_path), .tree_out_valid(tree_out_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_level(res_level),
    .res_path(res_path), .res_tag(res_tag), .timeout_err(timeout_err),
    .spurious_err(spurious_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every downstream handshake pops and compares one expected result.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_result", 32'(res_valid), 32'(0));
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sb_result", 32'({res_level, res_path, res_tag}), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [F*W-1:0] mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    return {c, b, a};
  endfunction

  task automatic accept(input logic [F*W-1:0] v);
    in_valid    = 1'b1;
    in_features = v;
    tick();
    in_valid    = 1'b0;
    in_features = '0;
  endtask

  // Called in the start cycle; leaves the bench in WAIT cycle 1.
  task automatic stream(input logic [F*W-1:0] v);
    for (int k = 0; k < F; k++) begin
      chk($sformatf("sample_f%0d", k), 32'(sample), 32'(v[k*W +: W]));
      chk("in_ready_busy", 32'(in_ready), 32'(0));
      tick();
    end
  endtask

  // Answer in WAIT cycle w (w >= 1).
  task automatic answer(input int w, input logic [LW-1:0] l, input logic [LW-1:0] p,
                        input logic [T-1:0] tg);
    res_t e;
    repeat (w - 1) tick();
    tree_out_valid = 1'b1;
    tree_level     = l;
    tree_path      = p;
    e.lvl = l; e.pth = p; e.tag = tg;
    exp_q.push_back(e);
    tick();
    tree_out_valid = 1'b0;
    chk("res_valid_rise", 32'(res_valid), 32'(1));
    chk("res_tag", 32'(res_tag), 32'(tg));
    chk("in_ready_after_capture", 32'(in_ready), 32'(1));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
    chk({tag, "_sample"}, 32'(sample), 32'(0));
    chk({tag, "_res"}, 32'({res_valid, res_level, res_path, res_tag}), 32'(0));
    chk({tag, "_errs"}, 32'({timeout_err, spurious_err}), 32'(0));
  endtask

  initial begin
    logic [F*W-1:0] v;
    reset = 1'b1; in_valid = 1'b0; in_features = '0; tree_ready = 1'b0;
    tree_out_valid = 1'b0; tree_level = '0; tree_path = '0; res_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_reset_vals("reset");

    // Basic vector {12,-3,511}, answer 3 cycles after the last feature.
    tree_ready = 1'b1;
    v = mk(10'd12, -10'sd3, 10'd511);
    accept(v);
    stream(v);
    answer(3, 2'd2, 2'd1, 4'd1);
    chk("basic_level", 32'(res_level), 32'(2));
    chk("basic_path", 32'(res_path), 32'(1));
    tick();
    chk("res_valid_drain", 32'(res_valid), 32'(0));

    // Ready stall: feature 0 held for 10 cycles, stream starts on first ready.
    tree_ready = 1'b0;
    v = mk(-10'sd512, 10'd1, 10'd100);
    accept(v);
    for (int i = 0; i < 10; i++) begin
      chk("stall_sample", 32'(sample), 32'(v[W-1:0]));
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      tick();
    end
    tree_ready = 1'b1;
    stream(v);
    answer(1, 2'd1, 2'd0, 4'd2);
    tick();

    // Backpressure: second vector accepted but not started while slot is full.
    res_ready = 1'b0;
    v = mk(10'd7, 10'd8, 10'd9);
    accept(v);
    stream(v);
    answer(2, 2'd3, 2'd3, 4'd3);
    v = mk(10'd300, -10'sd300, 10'd5);
    accept(v);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_sample", 32'(sample), 32'(v[W-1:0]));
      chk("bp_hold_result", 32'({res_valid, res_level, res_path, res_tag}),
          32'({1'b1, 2'd3, 2'd3, 4'd3}));
      tick();
    end
    res_ready = 1'b1;
    chk("bp_handshake_cycle_sample", 32'(sample), 32'(v[W-1:0]));
    tick();
    chk("bp_slot_empty", 32'(res_valid), 32'(0));
    stream(v);

    // Answer on the final (8th) WAIT cycle: captured, no timeout.
    answer(TO, 2'd2, 2'd3, 4'd4);
    chk("to_boundary_no_err", 32'(timeout_err), 32'(0));
    tick();

    // Timeout: no answer within 8 WAIT cycles.
    v = mk(10'd1, 10'd2, 10'd3);
    accept(v);
    stream(v);
    for (int i = 1; i < TO; i++) begin
      chk("to_waiting", 32'({in_ready, timeout_err}), 32'(0));
      tick();
    end
    chk("to_last_wait_cycle", 32'(in_ready), 32'(0));
    tick();
    chk("to_err", 32'(timeout_err), 32'(1));
    chk("to_idle", 32'(in_ready), 32'(1));
    chk("to_no_result", 32'(res_valid), 32'(0));
    chk("spurious_clear", 32'(spurious_err), 32'(0));

    // Spurious out_valid in IDLE.
    tree_out_valid = 1'b1;
    tick();
    tree_out_valid = 1'b0;
    chk("spurious_set", 32'(spurious_err), 32'(1));
    chk("spurious_no_result", 32'(res_valid), 32'(0));

    // Reset mid-SEND.
    v = mk(10'd40, 10'd41, 10'd42);
    accept(v);
    tick();
    chk("send_mid_sample", 32'(sample), 32'(10'd41));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_vals("midsend_reset");

    // Tag wrap: 17 vectors give tags 1..15, 0, 1.
    for (int i = 0; i < 17; i++) begin
      v = mk(W'(i), W'(3 * i), -W'(i));
      accept(v);
      stream(v);
      answer(1, LW'(i), LW'(i + 1), T'(i + 1));
    end
    tick(); tick();
    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
